keypad_code_lock: RTL
=====================

Name: keypad_code_lock

Overview:
- Consumes the one-cycle key strobe and key code from the 4x4 keypad scanner.
- Runs a 4-digit code-lock state machine: digit entry with backspace/clear, code compare, and unlock.
- Supports changing the code while unlocked, plus a lockout alarm after repeated failures.
- Drives the BCD entry buffer and status flags to the seven-segment/LED display stage downstream.

Parameters:
- DEFAULT_CODE, 16'h1234, code loaded at reset; 4 BCD digits, MSD in [15:12].
- MAX_FAIL, 3, consecutive failed confirms that trigger ALARM (1..3).
- ALARM_CYCLES, 50000000-1, ALARM dwell length in clk cycles minus 1; counter is 32 bits.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- key_en  input  1  one-cycle key strobe from the scanner
- key_num  input  4  key code; valid in the cycle after key_en and held until the next strobe
- digits  output  16  entry buffer, 4 BCD nibbles, newest digit in [3:0]
- digit_cnt  output  3  number of digits entered (0..4)
- unlocked  output  1  high in UNLOCKED and SET_NEW
- alarm  output  1  high in ALARM
- fail_cnt  output  2  consecutive failed confirms
- ok_pulse  output  1  one-cycle pulse on successful unlock or code change
- err_pulse  output  1  one-cycle pulse on a rejected confirm

Behaviour:
- Reset (async, active-high):
  - state = LOCKED; stored code = DEFAULT_CODE.
  - digits = 0, digit_cnt = 0, fail_cnt = 0.
  - unlocked, alarm, ok_pulse and err_pulse all 0; alarm timer = 0.
- Key strobe:
  - key_vld is key_en registered by one cycle.
  - key_num is sampled only when key_vld = 1.
  - All outputs are registered, so the effect appears 2 cycles after key_en.
- Key classes:
  - 0-9 = digit.
  - A = backspace, B = clear, C = confirm, D = change code, E = lock/abort.
  - F = ignored in every state.
- Digit entry (LOCKED and SET_NEW only):
  - digit with digit_cnt < 4: digits <= {digits[11:0], key}, digit_cnt + 1.
  - digit with digit_cnt = 4: ignored.
  - A with digit_cnt > 0: digits <= {4'h0, digits[15:4]}, digit_cnt - 1.
  - A with digit_cnt = 0: no change.
  - B: digits = 0, digit_cnt = 0.
- LOCKED:
  - C with digit_cnt = 4 and digits == code: go to UNLOCKED; ok_pulse; fail_cnt = 0; entry cleared.
  - C otherwise, including digit_cnt < 4: err_pulse; fail_cnt + 1; entry cleared.
  - If that increment makes fail_cnt equal MAX_FAIL: go to ALARM and load the timer with ALARM_CYCLES.
  - D and E are ignored.
- UNLOCKED:
  - D: go to SET_NEW with entry cleared.
  - E: go to LOCKED with entry cleared.
  - Digits, A, B and C are ignored.
- SET_NEW:
  - C with digit_cnt = 4: code <= digits; ok_pulse; go to UNLOCKED; entry cleared.
  - C with digit_cnt < 4: err_pulse; stay in SET_NEW; entry kept; fail_cnt unchanged.
  - E: go to UNLOCKED, code unchanged, entry cleared.
  - D is ignored.
- ALARM:
  - All strobes are ignored.
  - The timer decrements every cycle.
  - On the cycle the timer = 0: go to LOCKED, fail_cnt = 0, alarm drops next cycle.
  - A strobe coinciding with that exit cycle is ignored.
- Pulses: ok_pulse and err_pulse are high for exactly one cycle and are never high together.
- Only one key is processed per key_vld; strobes on back-to-back cycles are each processed in order.
- Reset mid-entry or mid-alarm returns to the reset state. A changed code reverts to DEFAULT_CODE.

Test Plan:
- Correct code: reset, keys 1,2,3,4,C -> digits steps 0001/0012/0123/1234; then unlocked = 1, ok_pulse x1, digits = 0, fail_cnt = 0.
- Editing keys: keys 5,6,A,7,B,9 -> digits 0005, 0056, 0005, 0057, 0000, 0009; digit_cnt 1,2,1,2,0,1.
- Overflow: keys 1,2,3,4,5 -> digits stays 1234, digit_cnt = 4.
- Lockout (sim ALARM_CYCLES = 20): keys 9,9,9,9,C three times -> err_pulse x3, fail_cnt 1,2,3.
  - alarm = 1 after the third confirm.
  - Keys 1,2,3,4,C pressed during ALARM have no effect.
  - After 21 cycles: alarm = 0, LOCKED, fail_cnt = 0.
- Code change: unlock with 1234, then D,5,6,7,8,C -> ok_pulse, unlocked = 1.
  - Then E; 1,2,3,4,C -> err_pulse.
  - Then 5,6,7,8,C -> unlocked = 1.
- Short code and reset: C with 2 digits in SET_NEW -> err_pulse, state stays SET_NEW.
  - Assert reset mid-entry -> all outputs 0 and code = 1234 again.

Source files
------------

// File: rtl/keypad_code_lock.sv
// Four-digit keypad code lock: digit entry with backspace/clear, code compare,
// code change while unlocked, and a timed lockout after repeated failures.
module keypad_code_lock #(
    parameter logic [15:0] DEFAULT_CODE = 16'h1234,
    parameter int          MAX_FAIL     = 3,
    parameter logic [31:0] ALARM_CYCLES = 32'd49_999_999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_en,
    input  logic [3:0]  key_num,
    output logic [15:0] digits,
    output logic [2:0]  digit_cnt,
    output logic        unlocked,
    output logic        alarm,
    output logic [1:0]  fail_cnt,
    output logic        ok_pulse,
    output logic        err_pulse
);

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        SET_NEW  = 2'd2,
        ALARM    = 2'd3
    } state_t;

    localparam logic [3:0] KEY_BS     = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_OK     = 4'hC;
    localparam logic [3:0] KEY_CHANGE = 4'hD;
    localparam logic [3:0] KEY_LOCK   = 4'hE;
    localparam logic [1:0] FAIL_LIMIT = 2'(MAX_FAIL);

    state_t      state_reg, state_next;
    logic [15:0] code_reg, code_next;
    logic [15:0] digits_reg, digits_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [1:0]  fail_reg, fail_next;
    logic [31:0] timer_reg, timer_next;
    logic        ok_reg, ok_next;
    logic        err_reg, err_next;
    logic        unlocked_reg, unlocked_next;
    logic        alarm_reg, alarm_next;
    logic        key_vld_reg;

    logic        is_digit;
    logic        entry_state;
    logic [1:0]  fail_inc;

    assign is_digit    = (key_num <= 4'd9);
    assign entry_state = (state_reg == LOCKED) || (state_reg == SET_NEW);
    assign fail_inc    = fail_reg + 2'd1;

    always_comb begin
        state_next  = state_reg;
        code_next   = code_reg;
        digits_next = digits_reg;
        cnt_next    = cnt_reg;
        fail_next   = fail_reg;
        timer_next  = timer_reg;
        ok_next     = 1'b0;
        err_next    = 1'b0;

        if (state_reg == ALARM) begin
            // Strobes are ignored for the whole dwell, including the exit cycle.
            if (timer_reg == 32'd0) begin
                state_next = LOCKED;
                fail_next  = 2'd0;
            end else begin
                timer_next = timer_reg - 32'd1;
            end
        end else if (key_vld_reg) begin
            if (entry_state) begin
                if (is_digit) begin
                    if (cnt_reg < 3'd4) begin
                        digits_next = {digits_reg[11:0], key_num};
                        cnt_next    = cnt_reg + 3'd1;
                    end
                end else if (key_num == KEY_BS) begin
                    if (cnt_reg != 3'd0) begin
                        digits_next = {4'h0, digits_reg[15:4]};
                        cnt_next    = cnt_reg - 3'd1;
                    end
                end else if (key_num == KEY_CLEAR) begin
                    digits_next = 16'h0;
                    cnt_next    = 3'd0;
                end
            end

            case (state_reg)
                LOCKED: begin
                    if (key_num == KEY_OK) begin
                        digits_next = 16'h0;
                        cnt_next    = 3'd0;
                        if (cnt_reg == 3'd4 && digits_reg == code_reg) begin
                            state_next = UNLOCKED;
                            ok_next    = 1'b1;
                            fail_next  = 2'd0;
                        end else begin
                            err_next  = 1'b1;
                            fail_next = fail_inc;
                            if (fail_inc == FAIL_LIMIT) begin
                                state_next = ALARM;
                                timer_next = ALARM_CYCLES;
                            end
                        end
                    end
                end
                UNLOCKED: begin
                    if (key_num == KEY_CHANGE || key_num == KEY_LOCK) begin
                        state_next  = (key_num == KEY_CHANGE) ? SET_NEW : LOCKED;
                        digits_next = 16'h0;
                        cnt_next    = 3'd0;
                    end
                end
                SET_NEW: begin
                    if (key_num == KEY_OK) begin
                        // A short new code is rejected but the partial entry is kept.
                        if (cnt_reg == 3'd4) begin
                            code_next   = digits_reg;
                            ok_next     = 1'b1;
                            state_next  = UNLOCKED;
                            digits_next = 16'h0;
                            cnt_next    = 3'd0;
                        end else begin
                            err_next = 1'b1;
                        end
                    end else if (key_num == KEY_LOCK) begin
                        state_next  = UNLOCKED;
                        digits_next = 16'h0;
                        cnt_next    = 3'd0;
                    end
                end
                default: ;
            endcase
        end

        unlocked_next = (state_next == UNLOCKED) || (state_next == SET_NEW);
        alarm_next    = (state_next == ALARM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= LOCKED;
            code_reg     <= DEFAULT_CODE;
            digits_reg   <= 16'h0;
            cnt_reg      <= 3'd0;
            fail_reg     <= 2'd0;
            timer_reg    <= 32'd0;
            ok_reg       <= 1'b0;
            err_reg      <= 1'b0;
            unlocked_reg <= 1'b0;
            alarm_reg    <= 1'b0;
            key_vld_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            code_reg     <= code_next;
            digits_reg   <= digits_next;
            cnt_reg      <= cnt_next;
            fail_reg     <= fail_next;
            timer_reg    <= timer_next;
            ok_reg       <= ok_next;
            err_reg      <= err_next;
            unlocked_reg <= unlocked_next;
            alarm_reg    <= alarm_next;
            key_vld_reg  <= key_en;
        end
    end

    assign digits    = digits_reg;
    assign digit_cnt = cnt_reg;
    assign unlocked  = unlocked_reg;
    assign alarm     = alarm_reg;
    assign fail_cnt  = fail_reg;
    assign ok_pulse  = ok_reg;
    assign err_pulse = err_reg;

endmodule
